// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU op sequencer: FSM state codes, instruction fields, reset values.
// Pure definitions; no latency or backpressure of its own.
package alu_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LD_A = 3'd1;
    localparam state_t ST_LD_B = 3'd2;
    localparam state_t ST_EXEC = 3'd3;
    localparam state_t ST_WB   = 3'd4;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int SUB_BIT  = 3;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]     op;
        logic                       sub;
        logic [DEST_MSB-DEST_LSB:0] dest;
    } instr_t;

    localparam state_t RST_STATE = ST_IDLE;
    localparam instr_t RST_INSTR = '0;

    function automatic instr_t unpack_instr(input logic [7:0] raw);
        instr_t r;
        r.op   = raw[OP_MSB:OP_LSB];
        r.sub  = raw[SUB_BIT];
        r.dest = raw[DEST_MSB:DEST_LSB];
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of instruction handshake, datapath controls and flags between sequencer and its neighbours.
// slave = the sequencer, master = decoder/datapath side.
interface alu_seq_if #(parameter int DEST_W = 2);
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr;
    logic              load_a;
    logic              load_b;
    logic [3:0]        op_new;
    logic              sub;
    logic              out_en;
    logic [7:0]        alu_result;
    logic              alu_cout;
    logic              load_dest;
    logic [DEST_W-1:0] dest_sel;
    logic              flag_c;
    logic              flag_z;
    logic              busy;
    logic              done;

    modport slave (
        input  instr_valid, instr, alu_result, alu_cout,
        output instr_ready, load_a, load_b, op_new, sub, out_en,
               load_dest, dest_sel, flag_c, flag_z, busy, done
    );

    modport master (
        output instr_valid, instr, alu_result, alu_cout,
        input  instr_ready, load_a, load_b, op_new, sub, out_en,
               load_dest, dest_sel, flag_c, flag_z, busy, done
    );
endinterface

// File: rtl/alu_flag_reg.sv
// Carry/zero flag register; captures on cap_en, flags visible the cycle after capture.
// No backpressure; async active-low clear.
module alu_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cap_en_i,
    input  logic       cout_i,
    input  logic [7:0] result_i,
    output logic       flag_c_o,
    output logic       flag_z_o
);
    logic flag_c_q, flag_c_d;
    logic flag_z_q, flag_z_d;

    always_comb begin
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (cap_en_i) begin
            flag_c_d = cout_i;
            flag_z_d = (result_i == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign flag_c_o = flag_c_q;
    assign flag_z_o = flag_z_q;
endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: IDLE->LD_A->LD_B->EXEC->WB, done 4 cycles after accept, 1 instr / 4 cycles.
// Ready only in IDLE/WB (valid elsewhere is ignored); flag register present only with ALU_SEQ_FLAGS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEST_W = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    state_t state_q, state_d;
    instr_t instr_q, instr_d;

    logic accept;
    logic in_wb;
    logic busy;

    assign bus.instr_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign in_wb           = (state_q == ST_WB);
    assign busy            = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LD_A;
                    instr_d = unpack_instr(bus.instr);
                end
            end
            ST_LD_A: state_d = ST_LD_B;
            ST_LD_B: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                // Accepting here chains straight into the next LD_A with no IDLE bubble.
                if (accept) begin
                    state_d = ST_LD_A;
                    instr_d = unpack_instr(bus.instr);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            instr_q <= RST_INSTR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Controls decode from registered state only; instr_q is masked in IDLE so stale ops never leak.
    assign bus.load_a    = (state_q == ST_LD_A);
    assign bus.load_b    = (state_q == ST_LD_B);
    assign bus.op_new    = busy ? instr_q.op  : 4'h0;
    assign bus.sub       = busy ? instr_q.sub : 1'b0;
    assign bus.dest_sel  = busy ? DEST_W'(instr_q.dest) : '0;
    assign bus.out_en    = in_wb;
    assign bus.load_dest = in_wb;
    assign bus.done      = in_wb;
    assign bus.busy      = busy;

    logic unused_rsvd;
    assign unused_rsvd = bus.instr[2];

`ifdef ALU_SEQ_FLAGS_EN
    alu_flag_reg u_flags (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en_i (in_wb),
        .cout_i   (bus.alu_cout),
        .result_i (bus.alu_result),
        .flag_c_o (bus.flag_c),
        .flag_z_o (bus.flag_z)
    );
`else
    logic unused_alu;
    assign unused_alu = ^{bus.alu_result, bus.alu_cout};
    assign bus.flag_c = 1'b0;
    assign bus.flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer plus a hand-written mid-instruction reset sequence.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    alu_seq_if #(.DEST_W(2)) bus ();

    alu_op_sequencer #(.DEST_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed bundle: {rdy,busy,la,lb,op[3:0],sub,oe,ld,dsel[1:0],done,fc,fz}
    typedef struct {
        logic        valid;
        logic [7:0]  instr;
        logic [7:0]  res;
        logic        cout;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // st: 0 idle, 1 LD_A, 2 LD_B, 3 EXEC, 4 WB
    function automatic logic [16:0] mk_exp(input int st, input logic [3:0] op, input logic sb,
                                           input logic [1:0] d, input logic fc, input logic fz);
        logic rdy, bsy, la, lb, wb;
        rdy = (st == 0) || (st == 4);
        bsy = (st != 0);
        la  = (st == 1);
        lb  = (st == 2);
        wb  = (st == 4);
        return {rdy, bsy, la, lb, op, sb, wb, wb, d, wb, fc & FLAGS_EN, fz & FLAGS_EN};
    endfunction

    task automatic add(input logic v, input logic [7:0] ins, input logic [7:0] res, input logic co,
                       input int st, input logic [3:0] op, input logic sb, input logic [1:0] d,
                       input logic fc, input logic fz);
        vec_t t;
        t.valid = v;
        t.instr = ins;
        t.res   = res;
        t.cout  = co;
        t.exp   = mk_exp(st, op, sb, d, fc, fz);
        vecs.push_back(t);
    endtask

    function automatic logic [16:0] observed();
        return {bus.instr_ready, bus.busy, bus.load_a, bus.load_b, bus.op_new, bus.sub,
                bus.out_en, bus.load_dest, bus.dest_sel, bus.done, bus.flag_c, bus.flag_z};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = observed();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // Non-WB cycles present res=FF/cout=1 so any capture outside WB is visible.
        // Single 8'h5A, WB result 00 / cout 1
        add(1, 8'h5A, 8'hFF, 1, 0, 4'h0, 0, 2'd0, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 1, 4'h5, 1, 2'd2, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 2, 4'h5, 1, 2'd2, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 3, 4'h5, 1, 2'd2, 0, 0);
        add(0, 8'h00, 8'h00, 1, 4, 4'h5, 1, 2'd2, 0, 0);
        // 8'h2F (reserved bit set), WB result 7F / cout 0
        add(1, 8'h2F, 8'hFF, 1, 0, 4'h0, 0, 2'd0, 1, 1);
        add(0, 8'h00, 8'hFF, 1, 1, 4'h2, 1, 2'd3, 1, 1);
        add(0, 8'h00, 8'hFF, 1, 2, 4'h2, 1, 2'd3, 1, 1);
        add(0, 8'h00, 8'hFF, 1, 3, 4'h2, 1, 2'd3, 1, 1);
        add(0, 8'h00, 8'h7F, 0, 4, 4'h2, 1, 2'd3, 1, 1);
        // Back-to-back 8'h10 then 8'h23 with valid held high
        add(1, 8'h10, 8'hFF, 1, 0, 4'h0, 0, 2'd0, 0, 0);
        add(1, 8'h23, 8'hFF, 1, 1, 4'h1, 0, 2'd0, 0, 0);
        add(1, 8'h23, 8'hFF, 1, 2, 4'h1, 0, 2'd0, 0, 0);
        add(1, 8'h23, 8'hFF, 1, 3, 4'h1, 0, 2'd0, 0, 0);
        add(1, 8'h23, 8'h01, 1, 4, 4'h1, 0, 2'd0, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 1, 4'h2, 0, 2'd3, 1, 0);
        add(0, 8'h00, 8'hFF, 1, 2, 4'h2, 0, 2'd3, 1, 0);
        add(0, 8'h00, 8'hFF, 1, 3, 4'h2, 0, 2'd3, 1, 0);
        add(0, 8'h00, 8'h00, 0, 4, 4'h2, 0, 2'd3, 1, 0);
        // 8'h44 accepted, then 8'h99 offered from LD_B: must wait for WB
        add(1, 8'h44, 8'hFF, 1, 0, 4'h0, 0, 2'd0, 0, 1);
        add(0, 8'h00, 8'hFF, 1, 1, 4'h4, 0, 2'd0, 0, 1);
        add(1, 8'h99, 8'hFF, 1, 2, 4'h4, 0, 2'd0, 0, 1);
        add(1, 8'h99, 8'hFF, 1, 3, 4'h4, 0, 2'd0, 0, 1);
        add(1, 8'h99, 8'h80, 0, 4, 4'h4, 0, 2'd0, 0, 1);
        add(0, 8'h00, 8'hFF, 1, 1, 4'h9, 1, 2'd1, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 2, 4'h9, 1, 2'd1, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 3, 4'h9, 1, 2'd1, 0, 0);
        add(0, 8'h00, 8'h00, 1, 4, 4'h9, 1, 2'd1, 0, 0);
        add(0, 8'h00, 8'hFF, 1, 0, 4'h0, 0, 2'd0, 1, 1);

        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        bus.alu_result  = 8'hFF;
        bus.alu_cout    = 1'b1;
        rst_n           = 1'b0;
        #1;
        check("reset_state", mk_exp(0, 4'h0, 0, 2'd0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.instr_valid = vecs[i].valid;
            bus.instr       = vecs[i].instr;
            bus.alu_result  = vecs[i].res;
            bus.alu_cout    = vecs[i].cout;
            #1;
            check($sformatf("vec[%0d]", i), vecs[i].exp);
            @(negedge clk);
        end

        // Reset asserted in EXEC: immediate abort, flags cleared, no done afterwards
        bus.instr_valid = 1'b1;
        bus.instr       = 8'h5A;
        bus.alu_result  = 8'h00;
        bus.alu_cout    = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_exec", mk_exp(3, 4'h5, 1, 2'd2, 1, 1));
        rst_n = 1'b0;
        #1;
        check("async_reset_exec", mk_exp(0, 4'h0, 0, 2'd0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("held_reset[%0d]", k), mk_exp(0, 4'h0, 0, 2'd0, 0, 0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_reset[%0d]", k), mk_exp(0, 4'h0, 0, 2'd0, 0, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
